// File: rtl/song_pkg.sv
`default_nettype none
// song_pkg: shared state encoding, song-entry layout and octave codes for song_player.
package song_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int ENTRY_W  = 10;
  localparam int NOTE_LSB = 0;
  localparam int NOTE_W   = 4;
  localparam int OCT_LSB  = 4;
  localparam int OCT_W    = 2;
  localparam int DUR_LSB  = 6;
  localparam int DUR_W    = 4;

  localparam logic [OCT_W-1:0]  OCT_BASE     = 2'b00;
  localparam logic [OCT_W-1:0]  OCT_UP       = 2'b01;
  localparam logic [OCT_W-1:0]  OCT_DOWN     = 2'b10;
  localparam logic [OCT_W-1:0]  OCT_BASE_ALT = 2'b11;
  localparam logic [DUR_W-1:0]  END_DUR      = 4'd0;
  localparam logic [NOTE_W-1:0] MAX_NOTE     = 4'd7;

  function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] e);
    return e[NOTE_LSB +: NOTE_W];
  endfunction

  function automatic logic [OCT_W-1:0] entry_oct(input logic [ENTRY_W-1:0] e);
    return e[OCT_LSB +: OCT_W];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
    return e[DUR_LSB +: DUR_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// song_rom: synchronous-read song table, ROM_DEPTH x ENTRY_W, one cycle of read latency.
module song_rom
  import song_pkg::*;
#(
  parameter int ROM_DEPTH = 64,
  parameter int AW        = 6
) (
  input  logic               clk,
  input  logic [AW-1:0]      addr,
  output logic [ENTRY_W-1:0] data
);

  // The song image (init file) is loaded into mem by the memory-initialisation flow.
  logic [ENTRY_W-1:0] mem [ROM_DEPTH];

  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/song_player.sv
`default_nettype none
// song_player: steps through song_rom entries with tick-based durations and lets a
// live key duck the playback voice while the sequencer keeps running underneath.
module song_player
  import song_pkg::*;
#(
  parameter int TICK_CYCLES = 12_500_000,
  parameter int ROM_DEPTH   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_note,
  input  logic       key_oct_up,
  input  logic       key_oct_down,
  input  logic       play_start,
  input  logic       play_stop,
  output logic [3:0] note,
  output logic       octave_up,
  output logic       octave_down,
  output logic       en,
  output logic       busy,
  output logic       done
);

  localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [AW-1:0] ADDR_LAST = AW'(ROM_DEPTH - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  state_t             state, state_nxt;
  logic [AW-1:0]      addr, addr_nxt;
  logic [TW-1:0]      tick_cnt, tick_nxt;
  logic [DUR_W-1:0]   dur_cnt, dur_nxt;
  logic [ENTRY_W-1:0] rom_data, cur_entry, entry;
  logic [NOTE_W-1:0]  entry_n, note_nxt;
  logic               tick, key_live, done_nxt, up_nxt, down_nxt;

  // The ROM is addressed with the next address so the entry is ready during FETCH.
  song_rom #(
    .ROM_DEPTH(ROM_DEPTH),
    .AW       (AW)
  ) u_rom (
    .clk (clk),
    .addr(addr_nxt),
    .data(rom_data)
  );

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      tick_cnt  <= '0;
      dur_cnt   <= '0;
      cur_entry <= '0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      tick_cnt <= tick_nxt;
      dur_cnt  <= dur_nxt;
      if (state == FETCH) begin
        cur_entry <= rom_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    tick_nxt  = tick_cnt;
    dur_nxt   = dur_cnt;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
      end
      FETCH: begin
        if (entry_dur(rom_data) == END_DUR) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = PLAY;
          tick_nxt  = '0;
          dur_nxt   = entry_dur(rom_data);
        end
      end
      PLAY: begin
        if (tick) begin
          tick_nxt = '0;
          dur_nxt  = dur_cnt - 1'b1;
          if (dur_cnt == 4'd1) begin
            state_nxt = GAP;
          end
        end else begin
          tick_nxt = tick_cnt + 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          tick_nxt = '0;
          if (addr == ADDR_LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = FETCH;
            addr_nxt  = addr + 1'b1;
          end
        end else begin
          tick_nxt = tick_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Stop overrides start and suppresses any end-of-song pulse.
    if (play_stop) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
      tick_nxt  = '0;
      dur_nxt   = '0;
    end else if (play_start) begin
      state_nxt = FETCH;
      addr_nxt  = '0;
      tick_nxt  = '0;
      done_nxt  = 1'b0;
    end
  end

  always_comb begin
    entry    = (state == FETCH) ? rom_data : cur_entry;
    entry_n  = entry_note(entry);
    key_live = (key_note != 4'd0) && (key_note <= MAX_NOTE);
    note_nxt = '0;
    up_nxt   = 1'b0;
    down_nxt = 1'b0;
    if (key_live) begin
      note_nxt = key_note;
      up_nxt   = key_oct_up & ~key_oct_down;
      down_nxt = key_oct_down & ~key_oct_up;
    end else if (state_nxt == PLAY) begin
      note_nxt = (entry_n <= MAX_NOTE) ? entry_n : '0;
      up_nxt   = (entry_oct(entry) == OCT_UP);
      down_nxt = (entry_oct(entry) == OCT_DOWN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note        <= '0;
      octave_up   <= 1'b0;
      octave_down <= 1'b0;
      en          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      note        <= note_nxt;
      octave_up   <= up_nxt;
      octave_down <= down_nxt;
      en          <= (note_nxt != 4'd0);
      busy        <= (state_nxt != IDLE);
      done        <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_song_player.sv
`default_nettype none
// tb_song_player: randomized scoreboard bench; a per-cycle timeline model of the song
// predicts every output frame, a monitor compares the DUT against it.
module tb_song_player;

  localparam int TICK  = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [3:0] note;
    logic       up;
    logic       dn;
    logic       en;
    logic       busy;
    logic       done;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_note;
  logic       key_oct_up, key_oct_down, play_start, play_stop;
  logic [3:0] note;
  logic       octave_up, octave_down, en, busy, done;

  song_player #(
    .TICK_CYCLES(TICK),
    .ROM_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_note    (key_note),
    .key_oct_up  (key_oct_up),
    .key_oct_down(key_oct_down),
    .play_start  (play_start),
    .play_stop   (play_stop),
    .note        (note),
    .octave_up   (octave_up),
    .octave_down (octave_down),
    .en          (en),
    .busy        (busy),
    .done        (done)
  );

  logic [9:0] song [DEPTH];
  frame_t     sched[$];
  frame_t     exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cnt_en, cnt_key6, cnt_up, cnt_dn, cnt_done;

  initial forever #5 clk = ~clk;

  function automatic frame_t mk(logic [3:0] n, logic u, logic d, logic b, logic dn_pulse);
    frame_t f;
    f.note = n; f.up = u; f.dn = d; f.en = (n != 4'd0); f.busy = b; f.done = dn_pulse;
    return f;
  endfunction

  // Whole-song timeline: fetch, duration*TICK of tone, TICK of silence, per entry.
  task automatic build_sched();
    logic [9:0] e;
    logic [3:0] n;
    int d;
    sched.delete();
    for (int i = 0; i < DEPTH; i++) begin
      e = song[i];
      d = int'(e[9:6]);
      n = (e[3:0] <= 4'd7) ? e[3:0] : 4'd0;
      sched.push_back(mk(4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      if (d == 0) begin
        sched.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        return;
      end
      for (int c = 0; c < d * TICK; c++)
        sched.push_back(mk(n, e[5:4] == 2'b01, e[5:4] == 2'b10, 1'b1, 1'b0));
      for (int c = 0; c < TICK; c++)
        sched.push_back(mk(4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    sched.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    frame_t f;
    forever begin
      @(posedge clk);
      f = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (rst) begin
        sched.delete();
      end else begin
        if (play_stop) sched.delete();
        else if (play_start) build_sched();
        if (sched.size() > 0) f = sched.pop_front();
        if (key_note >= 4'd1 && key_note <= 4'd7) begin
          f.note = key_note;
          f.up   = key_oct_up && !key_oct_down;
          f.dn   = key_oct_down && !key_oct_up;
          f.en   = 1'b1;
        end
      end
      exp_q.push_back(f);
    end
  end

  initial begin
    frame_t e, g;
    forever begin
      @(negedge clk);
      g = {note, octave_up, octave_down, en, busy, done};
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL frame_queue t=%0t got empty scoreboard, required one entry", $time);
      end else begin
        e = exp_q.pop_front();
        if (!rst) begin
          n_tests++;
          if (g !== e) begin
            n_fail++;
            $display("FAIL frame t=%0t got note=%0d up=%0b dn=%0b en=%0b busy=%0b done=%0b exp note=%0d up=%0b dn=%0b en=%0b busy=%0b done=%0b",
                     $time, g.note, g.up, g.dn, g.en, g.busy, g.done,
                     e.note, e.up, e.dn, e.en, e.busy, e.done);
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (en) cnt_en++;
    if (note == 4'd6) cnt_key6++;
    if (octave_up) cnt_up++;
    if (octave_down) cnt_dn++;
    if (done) cnt_done++;
  end

  task automatic check(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic load_song();
    for (int i = 0; i < DEPTH; i++) dut.u_rom.mem[i] = song[i];
  endtask

  task automatic clear_song();
    for (int i = 0; i < DEPTH; i++) song[i] = 10'd0;
  endtask

  task automatic clear_counts();
    cnt_en = 0; cnt_key6 = 0; cnt_up = 0; cnt_dn = 0; cnt_done = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) play_start = 1'b1;
    @(negedge clk) play_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) play_stop = 1'b1;
    @(negedge clk) play_stop = 1'b0;
  endtask

  task automatic run_until_idle(int max_cycles);
    bit drained;
    drained = 1'b0;
    for (int c = 0; c < max_cycles && !drained; c++) begin
      @(negedge clk);
      if (sched.size() == 0) drained = 1'b1;
    end
    if (!drained) begin
      n_tests++; n_fail++;
      $display("FAIL timeout got still playing after %0d cycles, required idle", max_cycles);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; key_note = 4'd0; key_oct_up = 1'b0; key_oct_down = 1'b0;
    play_start = 1'b0; play_stop = 1'b0;
    clear_counts();
    clear_song();
    load_song();
    repeat (2) @(negedge clk);
    check("reset_note", int'(note), 0);
    check("reset_en", int'(en), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_oct", int'({octave_up, octave_down}), 0);
    rst = 1'b0;

    // Single note then end marker.
    clear_song(); song[0] = {4'd2, 2'b00, 4'd3}; load_song(); clear_counts();
    pulse_start(); run_until_idle(200);
    check("basic_en_cycles", cnt_en, 2 * TICK);
    check("basic_done_pulses", cnt_done, 1);

    // Octave codes up and down.
    clear_song(); song[0] = {4'd1, 2'b01, 4'd5}; song[1] = {4'd1, 2'b10, 4'd5};
    load_song(); clear_counts();
    pulse_start(); run_until_idle(200);
    check("oct_up_cycles", cnt_up, TICK);
    check("oct_down_cycles", cnt_dn, TICK);

    // Live key ducks the playback without changing its length.
    clear_song(); song[0] = {4'd2, 2'b00, 4'd3}; load_song(); clear_counts();
    pulse_start();
    @(negedge clk) key_note = 4'd6;
    repeat (3) @(negedge clk);
    key_note = 4'd0;
    run_until_idle(200);
    check("duck_key_cycles", cnt_key6, 3);
    check("duck_en_cycles", cnt_en, 2 * TICK);
    check("duck_done_pulses", cnt_done, 1);

    // Asynchronous reset mid-play.
    clear_song(); song[0] = {4'd3, 2'b00, 4'd2}; load_song(); clear_counts();
    pulse_start();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_note", int'(note), 0);
    check("async_rst_en", int'(en), 0);
    check("async_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);

    // Start and stop together: stop wins.
    clear_counts();
    pulse_start();
    repeat (2) @(negedge clk);
    play_start = 1'b1; play_stop = 1'b1;
    @(negedge clk);
    play_start = 1'b0; play_stop = 1'b0;
    check("startstop_busy", int'(busy), 0);
    check("startstop_done", int'(done), 0);
    repeat (4) @(negedge clk);
    check("startstop_no_done", cnt_done, 0);

    // Every entry playable: ends after the last one without wrapping.
    for (int i = 0; i < DEPTH; i++)
      song[i] = {4'd1, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 7))};
    load_song(); clear_counts();
    pulse_start(); run_until_idle(DEPTH * (1 + 2 * TICK) + 20);
    repeat (10) @(negedge clk);
    check("full_done_pulses", cnt_done, 1);
    check("full_en_cycles", cnt_en, DEPTH * TICK);

    // Randomized songs, keys, starts and stops.
    for (int it = 0; it < 4; it++) begin
      pulse_stop();
      for (int i = 0; i < DEPTH; i++)
        song[i] = {($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 3)),
                   2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      load_song();
      pulse_start();
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        play_start = ($urandom_range(0, 79) == 0);
        play_stop  = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 7) == 0) begin
          key_note     = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          key_oct_up   = 1'($urandom_range(0, 1));
          key_oct_down = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      play_start = 1'b0; play_stop = 1'b0;
      key_note = 4'd0; key_oct_up = 1'b0; key_oct_down = 1'b0;
    end
    pulse_stop();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 Parameter TICK_CYCLES, default 12_500_000; clock cycles per duration tick (125 ms at 100 MHz); legal range 2 or more.
REQ-002 Parameter ROM_DEPTH, default 64; number of song entries; power of two.
REQ-003 Port clk, in, 1; single clock for the whole block.
REQ-004 Port rst, in, 1; asynchronous, active-high reset.
REQ-005 Port key_note, in, 4; live keyboard note, 0 = no key, 1..7 = do..si, 8..15 treated as 0.
REQ-006 Port key_oct_up / key_oct_down, in, 1 each; live octave modifiers.
REQ-007 Port play_start, in, 1; single-cycle pulse, starts playback from entry 0.
REQ-008 Port play_stop, in, 1; single-cycle pulse, aborts playback.
REQ-009 Port note, out, 4; note to the buzzer, 0..7 only.
REQ-010 Port octave_up / octave_down, out, 1 each; never both 1.
REQ-011 Port en, out, 1; buzzer enable; 1 exactly when note != 0.
REQ-012 Port busy, out, 1; 1 in any state other than IDLE.
REQ-013 Port done, out, 1; one-cycle pulse when a song ends at its end marker.

Function
REQ-014 Song entry is 10 bits: [3:0] note (0 = rest); [5:4] octave code (00 base, 01 up, 10 down, 11 base); [9:6] duration in ticks, where 0 is the end marker.
REQ-015 FSM states are IDLE, FETCH, PLAY, GAP.
- IDLE -> FETCH on play_start, with addr = 0.
- FETCH lasts 1 cycle for the registered ROM read.
- FETCH -> PLAY if duration != 0, otherwise IDLE with done = 1.
REQ-016 On entry to PLAY, tick_cnt = 0 and dur_cnt = duration.
- tick_cnt counts 0..TICK_CYCLES-1 and wraps; a tick occurs at the terminal count.
- dur_cnt decrements on each tick.
- On the tick with dur_cnt == 1, the FSM goes to GAP, so PLAY lasts exactly duration*TICK_CYCLES cycles.
REQ-017 GAP lasts exactly TICK_CYCLES cycles with a silent playback voice, then goes to FETCH with addr + 1.
REQ-018 If addr == ROM_DEPTH-1 at the end of GAP, the FSM goes to IDLE with done = 1; addr does not wrap.
REQ-019 play_stop in any non-IDLE state -> IDLE on the next edge; done stays 0.
REQ-020 play_start in a non-IDLE state restarts at FETCH with addr = 0.
REQ-021 play_stop and play_start asserted in the same cycle: stop wins.
REQ-022 Arbitration: when key_note is in 1..7, the live key drives note and octave; playback timing continues unaffected underneath (ducking, not pausing).
REQ-023 Otherwise, in PLAY the current entry drives the outputs; in all other states the outputs are 0.
REQ-024 All outputs are registered; a change on a key input appears at the outputs exactly 1 cycle later.
REQ-025 key_oct_up and key_oct_down both high: both outputs are 0 (base octave).
REQ-026 Out-of-range entry note (8..15) is played as a rest (note 0, en 0) for its full duration.

Reset
REQ-027 While rst = 1:
- state = IDLE, addr = 0, tick_cnt = 0, dur_cnt = 0;
- note = 0, octave_up = 0, octave_down = 0, en = 0, busy = 0, done = 0.
- These values are asynchronous: they take effect without a clock edge.
REQ-028 Reset mid-PLAY silences the outputs immediately; after release, the block waits in IDLE for play_start.

Structure
REQ-029 Shared package song_pkg holds:
- the state enum;
- entry field positions and widths;
- octave code constants;
- the END_DUR = 0 constant.
REQ-030 Sub-module song_rom: synchronous-read ROM, ROM_DEPTH x 10, 1-cycle latency, contents from an init file; all sequencing stays in song_player.

Verification (TICK_CYCLES = 4 for all scenarios)
REQ-031 Entry 0 = {dur 2, oct 00, note 3}, entry 1 = end marker; pulse play_start -> FETCH 1 cycle, then note = 3 / en = 1 for exactly 8 cycles, then 4 silent GAP cycles, then FETCH, then done pulses for 1 cycle and busy falls.
REQ-032 Entry {dur 1, oct 01, note 5} -> octave_up = 1 and octave_down = 0 for 4 cycles; with oct 10 -> octave_down = 1 for 4 cycles.
REQ-033 During PLAY of note 3, hold key_note = 6 for 3 cycles -> note = 6 starting 1 cycle later, back to 3 afterwards; total PLAY length unchanged.
REQ-034 Assert rst asynchronously mid-PLAY -> note, en and busy are 0 before the next clk edge; after release, state stays IDLE.
REQ-035 play_start and play_stop together during PLAY -> IDLE next cycle, busy = 0, done = 0.
REQ-036 All ROM_DEPTH entries non-end with dur 1 -> playback ends after entry ROM_DEPTH-1, done pulses, addr does not wrap to 0.
